// File: rtl/list_packer_if.sv
// Handshake bundle between the HoP element source, the packer and the
// AXI4-Stream sink. The master modport is the packer's view (it drives
// O_READY and the T* beat signals); the slave modport is the
// environment's view (element source plus stream consumer).
interface list_packer_if #(
  parameter int DW  = 32,
  parameter int DBW = 256
);
  logic [DW-1:0]    IN;
  logic             I_VALID;
  logic             I_LAST;
  logic             O_READY;
  logic [DBW-1:0]   TDATA;
  logic             TVALID;
  logic             TREADY;
  logic             TLAST;
  logic [DBW/8-1:0] TKEEP;

  modport master (
    input  IN, I_VALID, I_LAST, TREADY,
    output O_READY, TDATA, TVALID, TLAST, TKEEP
  );

  modport slave (
    output IN, I_VALID, I_LAST, TREADY,
    input  O_READY, TDATA, TVALID, TLAST, TKEEP
  );
endinterface

// File: rtl/list_packer.sv
// Packs a stream of DW-bit list elements, lowest lane first, into DBW-bit
// AXI4-Stream beats. TLAST marks the end of each list and TKEEP trims the
// final partial beat. A fill register collects lanes. A separate output
// register holds the beat on the bus. This lets one completed beat wait
// (PENDING) while the output is stalled.
module list_packer #(
  parameter int DW  = 32,
  parameter int DBW = 256
) (
  input  logic          ACLK,
  input  logic          ARESETn,
  list_packer_if.master bus
);
  localparam int FS = DBW / DW;
  localparam int CW = $clog2(FS) + 1;
  localparam int KW = DBW / 8;
  localparam int LB = DW / 8;

  typedef enum logic [0:0] {FILLING, PENDING} state_e;

  state_e         state_q, state_d;
  logic [DBW-1:0] fill_data_q, fill_data_d;
  logic [CW-1:0]  fill_cnt_q, fill_cnt_d;
  logic           fill_last_q, fill_last_d;
  logic [DBW-1:0] out_data_q, out_data_d;
  logic [KW-1:0]  out_keep_q, out_keep_d;
  logic           out_last_q, out_last_d;
  logic           out_valid_q, out_valid_d;
  logic           run_q;

  logic [CW-1:0]  cnt_inc;
  logic [DBW-1:0] merged_data;
  logic [KW-1:0]  merged_keep;
  logic [KW-1:0]  pend_keep;
  logic           accept;
  logic           xfer;
  logic           out_free;
  logic           beat_done;

  assign cnt_inc = fill_cnt_q + CW'(1);

  // Per-lane views of the beat. merged_* is the fill register with the
  // incoming element written into lane[count]. pend_keep covers the beat
  // parked in the fill register while the output is stalled.
  generate
    for (genvar gi = 0; gi < FS; gi++) begin : g_lane
      assign merged_data[gi*DW +: DW] = (fill_cnt_q == CW'(gi)) ? bus.IN
                                                              : fill_data_q[gi*DW +: DW];
      assign merged_keep[gi*LB +: LB] = {LB{cnt_inc > CW'(gi)}};
      assign pend_keep[gi*LB +: LB]   = {LB{fill_cnt_q > CW'(gi)}};
    end
  endgenerate

  // run_q keeps O_READY low until the first edge after reset releases.
  assign bus.O_READY = run_q && (state_q == FILLING);
  assign accept      = bus.I_VALID && bus.O_READY;
  assign xfer        = out_valid_q && bus.TREADY;
  assign out_free    = !out_valid_q || bus.TREADY;
  assign beat_done   = accept && ((cnt_inc == CW'(FS)) || bus.I_LAST);

  assign bus.TDATA  = out_data_q;
  assign bus.TKEEP  = out_keep_q;
  assign bus.TLAST  = out_last_q;
  assign bus.TVALID = out_valid_q;

  // Next-state: lane filling, beat completion and output register hand-off.
  always_comb begin
    state_d     = state_q;
    fill_data_d = fill_data_q;
    fill_cnt_d  = fill_cnt_q;
    fill_last_d = fill_last_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    // A transfer empties the output unless something reloads it below.
    // Clearing TKEEP here keeps it zero whenever TVALID is low.
    if (xfer) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_keep_d  = '0;
      out_last_d  = 1'b0;
    end

    case (state_q)
      FILLING: begin
        if (beat_done) begin
          if (out_free) begin
            out_data_d  = merged_data;
            out_keep_d  = merged_keep;
            out_last_d  = bus.I_LAST;
            out_valid_d = 1'b1;
            fill_data_d = '0;
            fill_cnt_d  = '0;
            fill_last_d = 1'b0;
          end else begin
            // Park the completed beat in the fill register.
            fill_data_d = merged_data;
            fill_cnt_d  = cnt_inc;
            fill_last_d = bus.I_LAST;
            state_d     = PENDING;
          end
        end else if (accept) begin
          fill_data_d = merged_data;
          fill_cnt_d  = cnt_inc;
        end
      end
      PENDING: begin
        if (xfer) begin
          out_data_d  = fill_data_q;
          out_keep_d  = pend_keep;
          out_last_d  = fill_last_q;
          out_valid_d = 1'b1;
          fill_data_d = '0;
          fill_cnt_d  = '0;
          fill_last_d = 1'b0;
          state_d     = FILLING;
        end
      end
      default: state_d = FILLING;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q     <= FILLING;
      fill_data_q <= '0;
      fill_cnt_q  <= '0;
      fill_last_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_data_q <= fill_data_d;
      fill_cnt_q  <= fill_cnt_d;
      fill_last_q <= fill_last_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      run_q       <= 1'b1;
    end
  end
endmodule

// File: doc/list_packer.md
Name: list_packer

Overview:
- Write-direction counterpart to the list cache.
- Accepts a stream of DW-bit list elements from a HoP module over a valid/ready handshake.
- Packs them lane by lane into DBW-bit beats, lowest lane first, and emits those beats as AXI4-Stream master traffic.
- Marks the end of each list with TLAST and trims partial final beats with TKEEP, so lists of any length round-trip through memory.

Parameters:
- DW, 32: element width in bits. Must be a multiple of 8.
- DBW, 256: stream data bus width in bits. Must be an integer multiple of DW.
- FS (localparam), DBW/DW: elements per beat.
- CW (localparam), $clog2(FS)+1: lane counter width.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  reset, synchronous, active-low.
- IN  in  DW  list element from the HoP module.
- I_VALID  in  1  IN is valid.
- I_LAST  in  1  IN is the final element of the list; qualified by I_VALID.
- O_READY  out  1  packer accepts IN this cycle.
- TDATA  out  DBW  packed beat; lane k is TDATA[k*DW +: DW].
- TVALID  out  1  beat valid.
- TREADY  in  1  downstream accepts beat.
- TLAST  out  1  beat holds the final element of a list.
- TKEEP  out  DBW/8  byte enables, one per valid byte.

Behaviour:
- Handshakes:
  - Element accept = I_VALID & O_READY.
  - Beat transfer = TVALID & TREADY.
  - Both are evaluated on the ACLK rising edge.
- Reset (ARESETn low at a clock edge):
  - TVALID=0, TDATA=0, TLAST=0, TKEEP=0, O_READY=0, lane count=0, fill state=FILLING.
  - O_READY goes to 1 on the first edge with ARESETn high.
  - Reset mid-list silently discards the partial beat and any pending beat; the next element lands in lane 0.
- Storage:
  - Fill register: DBW data, lane count (CW bits), last flag.
  - Output register: drives TDATA/TKEEP/TLAST/TVALID.
- Fill state machine:
  - FILLING: O_READY=1.
    - On accept: IN is written to lane[count] and count increments.
    - The beat completes when count becomes FS or I_LAST=1.
  - Completed beat, output register free this cycle (TVALID=0, or a beat transfer in the same cycle):
    - Beat loads directly into the output register at that edge.
    - Fill register clears and count returns to 0.
    - State stays FILLING.
  - Completed beat, output register busy: state goes to PENDING.
  - PENDING: O_READY=0.
    - On a beat transfer, the pending beat moves into the output register at that edge, TVALID stays 1, and the fill register clears.
    - State returns to FILLING, so O_READY=1 the following cycle.
- Latency and throughput:
  - The element completing a beat at edge N gives TVALID=1 after edge N.
  - With TREADY held at 1, one beat is emitted per FS accepted elements with no bubbles on either side.
- Output stability: while TVALID=1 and TREADY=0, TDATA, TKEEP and TLAST hold constant (AXI4-Stream rule).
- TVALID clears only on a transfer with no completed beat ready to load.
- TKEEP:
  - Each of the n filled lanes sets its DW/8 byte bits; unfilled lanes give 0 bits and zero data.
  - A full beat gives all ones.
  - TKEEP is 0 whenever TVALID=0.
- TLAST is 1 only on a beat completed by an I_LAST element. An I_LAST landing on lane FS-1 gives a full beat with TLAST=1.
- Boundaries:
  - I_LAST on lane 0 produces a 1-lane beat.
  - A list whose length is a multiple of FS produces no extra empty beat.
  - The counter never exceeds FS.
- No TDEST/TID/TUSER outputs; the interconnect ties them off.

Test Plan (DW=32, DBW=256, FS=8):
1. Pulse reset, then hold TREADY=1 and push elements 1..8 back-to-back with I_LAST=0 -> after the 8th accept edge: one beat, TDATA lane k = k+1, TKEEP=32'hFFFFFFFF, TLAST=0, TVALID high for exactly 1 cycle, O_READY never drops.
2. Push 0xA, 0xB, 0xC with I_LAST on 0xC, TREADY=1 -> TDATA lanes 0..2 = A,B,C, lanes 3..7 = 0, TKEEP=32'h00000FFF, TLAST=1; the next element lands in lane 0 of a new beat.
3. Backpressure: TREADY=0, push 16 elements 0..15 ->
   - first beat (0..7) holds stable;
   - after the 16th accept, state=PENDING and O_READY=0; a 17th I_VALID is not accepted;
   - raise TREADY -> beat 0..7, then beat 8..15 on consecutive cycles;
   - O_READY=1 the cycle after the first transfer.
4. Same-cycle transfer and completion: TREADY=1 on the edge the 16th element arrives while beat 0..7 is still valid -> beat 8..15 loads at that edge, TVALID stays 1, no bubble, no PENDING.
5. Reset mid-list:
   - after 5 elements, assert ARESETn=0 for 1 cycle -> TVALID=0, O_READY=0 during reset;
   - then push 8 elements 0x20..0x27 -> one beat with lane 0 = 0x20, no residue from before the reset.
6. I_LAST on the 8th element (values 1..8) -> TKEEP all ones, TLAST=1, exactly one beat, no trailing empty beat.
